// File: rtl/divider_datapath_if.sv
// Command and result bundle between the divider sequencer (master) and the
// datapath that executes its per-cycle commands (slave).
interface divider_datapath_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             load;
  logic             add;
  logic             shift;
  logic             inbit;
  logic [1:0]       sel;
  logic             valid;
  logic             sign;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;
  logic             done;

  modport master (
    output dividend, divisor, load, add, shift, inbit, sel, valid,
    input  sign, quotient, remainder, div_zero, done
  );

  modport slave (
    input  dividend, divisor, load, add, shift, inbit, sel, valid,
    output sign, quotient, remainder, div_zero, done
  );
endinterface

// File: rtl/divider_datapath.sv
// Restoring-division datapath: holds divisor and the {hi, lo} partial
// remainder, executes sequencer commands, and captures results on valid.
module divider_datapath #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               reset,
  divider_datapath_if.slave dp
);

  localparam int REM_W = 2 * WIDTH + 1;

  logic [WIDTH-1:0] div_r;
  logic [REM_W-1:0] rem_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             div_zero_r;
  logic             done_r;

  logic [WIDTH:0]   hi_s;
  logic [WIDTH-1:0] lo_s;
  logic [WIDTH:0]   div_ext_s;
  logic [WIDTH:0]   alu_s;
  logic [REM_W-1:0] mux_s;
  logic [REM_W-1:0] rem_next_s;

  assign hi_s      = rem_r[REM_W-1:WIDTH];
  assign lo_s      = rem_r[WIDTH-1:0];
  assign div_ext_s = {1'b0, div_r};

  // ALU: restore (add) or trial subtract on the extended high half.
  always_comb begin
    alu_s = hi_s - div_ext_s;
    if (dp.add) begin
      alu_s = hi_s + div_ext_s;
    end else begin
      alu_s = hi_s - div_ext_s;
    end
  end

  // Borrow of the trial subtract goes straight to the sequencer, unregistered.
  assign dp.sign = alu_s[WIDTH];

  // REM input mux and optional left shift with inbit at the LSB.
  always_comb begin
    mux_s = rem_r;
    case (dp.sel)
      2'b00:   mux_s = rem_r;
      2'b01:   mux_s = {alu_s, lo_s};
      2'b10:   mux_s = {{(WIDTH + 1){1'b0}}, dp.dividend};
      2'b11:   mux_s = rem_r;
      default: mux_s = rem_r;
    endcase
    if (dp.shift) begin
      rem_next_s = {mux_s[REM_W-2:0], dp.inbit};
    end else begin
      rem_next_s = mux_s;
    end
  end

  // Working registers: divisor and partial remainder.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_r      <= {WIDTH{1'b0}};
      rem_r      <= {REM_W{1'b0}};
      div_zero_r <= 1'b0;
    end else begin
      rem_r <= rem_next_s;
      if (dp.load) begin
        div_r      <= dp.divisor;
        div_zero_r <= (dp.divisor == {WIDTH{1'b0}});
      end else begin
        div_r      <= div_r;
        div_zero_r <= div_zero_r;
      end
    end
  end

  // Result capture; the remainder sits one bit left because the last step shifts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      done_r      <= 1'b0;
    end else begin
      done_r <= dp.valid;
      if (dp.valid) begin
        quotient_r  <= rem_next_s[WIDTH-1:0];
        remainder_r <= rem_next_s[REM_W-1:WIDTH+1];
      end else begin
        quotient_r  <= quotient_r;
        remainder_r <= remainder_r;
      end
    end
  end

  assign dp.quotient  = quotient_r;
  assign dp.remainder = remainder_r;
  assign dp.div_zero  = div_zero_r;
  assign dp.done      = done_r;

endmodule

// File: tb/tb_divider_datapath.sv
// Directed bench for divider_datapath: the bench plays the sequencer and
// checks results against hand-computed quotients, remainders and borrows.
module tb_divider_datapath;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  divider_datapath_if #(.WIDTH(8)) dif ();

  divider_datapath #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .dp    (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle_cmds();
    dif.load  = 1'b0;
    dif.add   = 1'b0;
    dif.shift = 1'b0;
    dif.inbit = 1'b0;
    dif.sel   = 2'b00;
    dif.valid = 1'b0;
  endtask

  // Acts as the sequencer; n_iter < 8 stops early without capturing.
  task automatic run_div(input logic [7:0] dd, input logic [7:0] dv, input int n_iter,
                         input bit gaps, input bit xs, input bit chk_sign,
                         input logic [7:0] exp_sign, input logic [7:0] exp_q,
                         input logic [7:0] exp_r, input string tag);
    logic s;
    @(negedge clk);
    dif.dividend = dd;
    dif.divisor  = dv;
    dif.load     = 1'b1;
    dif.shift    = 1'b1;
    dif.inbit    = 1'b0;
    dif.sel      = 2'b10;
    dif.add      = xs ? 1'bx : 1'b0;
    dif.valid    = 1'b0;
    for (int i = 0; i < n_iter; i++) begin
      if (gaps && i > 0) begin
        @(negedge clk);
        idle_cmds();
        dif.add   = 1'bx;
        dif.inbit = 1'bx;
      end
      @(negedge clk);
      dif.dividend = ~dd;
      dif.divisor  = ~dv;
      dif.load     = 1'b0;
      dif.add      = 1'b0;
      dif.shift    = 1'b0;
      dif.inbit    = xs ? 1'bx : 1'b0;
      dif.sel      = 2'b01;
      dif.valid    = 1'b0;
      #1;
      s = dif.sign;
      if (chk_sign) check({tag, "_sign"}, {15'd0, s}, {15'd0, exp_sign[7-i]});
      @(negedge clk);
      if (i == 7) check({tag, "_done_pre"}, {15'd0, dif.done}, 16'd0);
      if (s) begin
        dif.add   = 1'b1;
        dif.inbit = 1'b0;
        dif.sel   = 2'b01;
      end else begin
        dif.add   = xs ? 1'bx : 1'b0;
        dif.inbit = 1'b1;
        dif.sel   = 2'b11;
      end
      dif.shift = 1'b1;
      dif.valid = (i == 7);
    end
    if (n_iter == 8) begin
      @(negedge clk);
      idle_cmds();
      check({tag, "_done"}, {15'd0, dif.done}, 16'd1);
      check({tag, "_q"}, {8'd0, dif.quotient}, {8'd0, exp_q});
      check({tag, "_r"}, {8'd0, dif.remainder}, {8'd0, exp_r});
      check({tag, "_dz"}, {15'd0, dif.div_zero}, {15'd0, (dv == 8'd0)});
      @(negedge clk);
      check({tag, "_done_off"}, {15'd0, dif.done}, 16'd0);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    dif.dividend = 8'd0;
    dif.divisor  = 8'd0;
    idle_cmds();
    #12;
    check("rst_q", {8'd0, dif.quotient}, 16'd0);
    check("rst_r", {8'd0, dif.remainder}, 16'd0);
    check("rst_dz", {15'd0, dif.div_zero}, 16'd0);
    check("rst_done", {15'd0, dif.done}, 16'd0);
    check("rst_sign", {15'd0, dif.sign}, 16'd0);
    @(negedge clk);
    reset = 1'b0;

    // 100/7: quotient 0000_1110, so borrows are the inverted bits 1111_0001.
    run_div(8'd100, 8'd7, 8, 1'b0, 1'b0, 1'b1, 8'b1111_0001, 8'd14, 8'd2, "d100_7");

    // valid on back-to-back edges with REM held: each captures, done stays high.
    @(negedge clk);
    dif.valid = 1'b1;
    @(negedge clk);
    check("b2b_done1", {15'd0, dif.done}, 16'd1);
    @(negedge clk);
    dif.valid = 1'b0;
    check("b2b_done2", {15'd0, dif.done}, 16'd1);
    check("b2b_q", {8'd0, dif.quotient}, 16'd14);
    @(negedge clk);
    check("b2b_done_off", {15'd0, dif.done}, 16'd0);

    run_div(8'd255, 8'd1, 8, 1'b0, 1'b0, 1'b0, 8'd0, 8'd255, 8'd0, "d255_1");
    run_div(8'd255, 8'd128, 8, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 8'd127, "d255_128");
    run_div(8'd200, 8'd255, 8, 1'b0, 1'b0, 1'b1, 8'hFF, 8'd0, 8'd200, "d200_255");
    run_div(8'd77, 8'd0, 8, 1'b0, 1'b0, 1'b0, 8'd0, 8'd255, 8'd77, "d77_0");

    // Abandon 100/7 in the subtract cycle of iteration 4.
    run_div(8'd100, 8'd7, 3, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, "abort");
    @(negedge clk);
    dif.add   = 1'b0;
    dif.shift = 1'b0;
    dif.sel   = 2'b01;
    #1;
    reset = 1'b1;
    #1;
    check("arst_q", {8'd0, dif.quotient}, 16'd0);
    check("arst_r", {8'd0, dif.remainder}, 16'd0);
    check("arst_dz", {15'd0, dif.div_zero}, 16'd0);
    check("arst_done", {15'd0, dif.done}, 16'd0);
    idle_cmds();
    dif.valid = 1'b1;
    repeat (2) @(negedge clk);
    check("arst_hold_done", {15'd0, dif.done}, 16'd0);
    dif.valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("arst_after_done", {15'd0, dif.done}, 16'd0);
    run_div(8'd9, 8'd3, 8, 1'b0, 1'b0, 1'b0, 8'd0, 8'd3, 8'd0, "d9_3");

    // Hold cycles and X on unused add/inbit must not change the result.
    run_div(8'd100, 8'd7, 8, 1'b1, 1'b1, 1'b1, 8'b1111_0001, 8'd14, 8'd2, "d100_7_gx");

    // A load mid-operation restarts with only the new operands.
    run_div(8'd50, 8'd5, 4, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, "restart");
    run_div(8'd255, 8'd128, 8, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 8'd127, "restart_255_128");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
